// File: rtl/encode_arb_pkg.sv
// rtl/encode_arb_pkg.sv - shared types and defaults for the encoder job arbiter
package encode_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int NCH        = 2;
   localparam int CNT_W_DEF  = 20;
   localparam int WDOG_W_DEF = 16;

endpackage

// File: rtl/encode_arb_rr.sv
// rtl/encode_arb_rr.sv - two-input round-robin picker, request vector plus pointer to one-hot grant
module encode_arb_rr
   import encode_arb_pkg::*;
(
   input  logic [NCH-1:0] i_req,
   input  logic           i_ptr,
   output logic [NCH-1:0] o_gnt
);

   // Contention is settled by the pointer; a lone request wins outright.
   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = i_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/encode_arb.sv
// rtl/encode_arb.sv - job-level round-robin sequencer sharing one encode core between two source channels
module encode_arb
   import encode_arb_pkg::*;
#(
   parameter int                DW       = 64,
   parameter int                CNT_W    = CNT_W_DEF,
   parameter int                WDOG_W   = WDOG_W_DEF,
   parameter logic [WDOG_W-1:0] WDOG_MAX = '1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    s0_fi,
   input  logic             s0_empty,
   input  logic             s0_last,
   output logic             s0_getn,
   input  logic [DW-1:0]    s1_fi,
   input  logic             s1_empty,
   input  logic             s1_last,
   output logic             s1_getn,
   output logic [DW-1:0]    enc_fi,
   output logic             enc_src_empty,
   output logic             enc_m_last,
   input  logic             enc_m_src_getn,
   input  logic             enc_m_dst_putn,
   input  logic             enc_m_endn,
   output logic [NCH-1:0]   gnt,
   output logic             busy,
   output logic [NCH-1:0]   done,
   output logic             err,
   output logic [CNT_W-1:0] job_src_words,
   output logic [CNT_W-1:0] job_dst_words
);

   state_t              r_state;
   logic [NCH-1:0]      r_gnt;
   logic                r_idx;
   logic                r_ptr;
   logic                r_busy;
   logic [NCH-1:0]      r_done;
   logic                r_err;
   logic [CNT_W-1:0]    r_src_cnt;
   logic [CNT_W-1:0]    r_dst_cnt;
   logic [WDOG_W-1:0]   r_wdog;
   logic [CNT_W-1:0]    r_job_src;
   logic [CNT_W-1:0]    r_job_dst;

   logic [NCH-1:0]      w_req;
   logic [NCH-1:0]      w_pick;
   logic                w_run;
   logic                w_active;
   logic [DW-1:0]       w_sel_fi;
   logic                w_sel_empty;
   logic                w_sel_last;
   logic                w_get;
   logic                w_put;
   logic [CNT_W-1:0]    w_src_next;
   logic [CNT_W-1:0]    w_dst_next;
   logic [WDOG_W-1:0]   w_wdog_inc;

   assign w_req = {~s1_empty, ~s0_empty};

   encode_arb_rr u_rr (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick)
   );

   assign w_run    = (r_state == ST_RUN);
   assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

   assign w_sel_fi    = r_idx ? s1_fi    : s0_fi;
   assign w_sel_empty = r_idx ? s1_empty : s0_empty;
   assign w_sel_last  = r_idx ? s1_last  : s0_last;

   // Zero-latency source path, only open while a job is streaming.
   assign enc_fi        = w_run ? w_sel_fi    : '0;
   assign enc_src_empty = w_run ? w_sel_empty : 1'b1;
   assign enc_m_last    = w_run ? w_sel_last  : 1'b0;
   assign s0_getn       = (w_run && !r_idx) ? enc_m_src_getn : 1'b1;
   assign s1_getn       = (w_run &&  r_idx) ? enc_m_src_getn : 1'b1;

   assign w_get      = w_run && !enc_m_src_getn;
   assign w_put      = w_active && !enc_m_dst_putn;
   assign w_src_next = (w_get && (r_src_cnt != '1)) ? r_src_cnt + 1'b1 : r_src_cnt;
   assign w_dst_next = (w_put && (r_dst_cnt != '1)) ? r_dst_cnt + 1'b1 : r_dst_cnt;
   assign w_wdog_inc = r_wdog + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_idx     <= 1'b0;
         r_ptr     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= '0;
         r_err     <= 1'b0;
         r_src_cnt <= '0;
         r_dst_cnt <= '0;
         r_wdog    <= '0;
         r_job_src <= '0;
         r_job_dst <= '0;
      end else begin
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_pick) begin
                  r_gnt     <= w_pick;
                  r_idx     <= w_pick[1];
                  r_src_cnt <= '0;
                  r_dst_cnt <= '0;
                  r_wdog    <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_src_cnt <= w_src_next;
               r_dst_cnt <= w_dst_next;
               if (w_get && w_sel_last) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_dst_cnt <= w_dst_next;
               r_wdog    <= w_wdog_inc;
               // Results are latched here so they are valid alongside the done pulse.
               if (!enc_m_endn || (w_wdog_inc == WDOG_MAX)) begin
                  r_done    <= r_gnt;
                  r_err     <= enc_m_endn;
                  r_job_src <= r_src_cnt;
                  r_job_dst <= w_dst_next;
                  r_busy    <= 1'b0;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ptr   <= ~r_idx;
               r_gnt   <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt           = r_gnt;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign job_src_words = r_job_src;
   assign job_dst_words = r_job_dst;

endmodule

// File: tb/tb_encode_arb.sv
// tb/tb_encode_arb.sv - randomized scoreboard bench for the encoder job arbiter
module tb_encode_arb;

   localparam int WDOG = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s0_fi, s1_fi, enc_fi;
   logic        s0_empty, s0_last, s0_getn, s1_empty, s1_last, s1_getn;
   logic        enc_src_empty, enc_m_last, enc_m_src_getn, enc_m_dst_putn, enc_m_endn;
   logic [1:0]  gnt, done;
   logic        busy, err;
   logic [19:0] job_src_words, job_dst_words;

   always #5 clk = ~clk;

   encode_arb #(.DW(64), .CNT_W(20), .WDOG_W(16), .WDOG_MAX(16'd8)) dut (
      .clk(clk), .rst(rst),
      .s0_fi(s0_fi), .s0_empty(s0_empty), .s0_last(s0_last), .s0_getn(s0_getn),
      .s1_fi(s1_fi), .s1_empty(s1_empty), .s1_last(s1_last), .s1_getn(s1_getn),
      .enc_fi(enc_fi), .enc_src_empty(enc_src_empty), .enc_m_last(enc_m_last),
      .enc_m_src_getn(enc_m_src_getn), .enc_m_dst_putn(enc_m_dst_putn), .enc_m_endn(enc_m_endn),
      .gnt(gnt), .busy(busy), .done(done), .err(err),
      .job_src_words(job_src_words), .job_dst_words(job_dst_words)
   );

   typedef struct { int ch; int src; int dst; int to; int cyc; } exp_t;
   exp_t sb[$];

   int n_checks = 0, n_errs = 0;
   int tick = 0;
   bit mon_on = 1'b0;
   int mon_j = 0, NJ = 0;
   int ex_ch[32], ex_len[32], ex_to[32], ex_dly[32];
   logic [63:0] wd[2][0:63];
   bit          wl[2][0:63];
   int wp[2], wn[2], pj[2];
   int njc[2], rem[2], kk[2];
   int lens[2][8], tos[2][8], dlys[2][8];
   int ptr, pick, cyc;
   int e_phase, e_started, e_dcnt, e_dst, jidx;
   bit e_pulled;
   bit pop[2];

   always @(posedge clk) tick <= tick + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: each done pulse is matched against the oldest expected job.
   always @(negedge clk) begin
      if (mon_on) begin
         check("err_only_with_done", {63'd0, err & ~|done}, 64'd0);
         if (done != 2'b00) begin
            check("sb_has_entry", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("done_onehot", done, (e.ch == 0) ? 2'b01 : 2'b10);
               check("done_err", err, e.to);
               check("job_src_words", job_src_words, e.src);
               check("job_dst_words", job_dst_words, e.dst);
               check("done_cycle", tick, e.cyc);
               mon_j++;
            end
         end
         if (busy && mon_j < NJ) check("gnt_during_job", gnt, (ex_ch[mon_j] == 0) ? 2'b01 : 2'b10);
      end
   end

   task automatic apply_pops();
      for (int c = 0; c < 2; c++) begin
         if (pop[c]) begin
            check("src_pop_in_range", {63'd0, wp[c] < wn[c]}, 64'd1);
            if (wp[c] < wn[c]) begin
               if (wl[c][wp[c]]) pj[c] = 0;
               else pj[c]++;
               wp[c]++;
            end
         end
      end
   endtask

   task automatic drive_sources();
      bit avail, stall;
      for (int c = 0; c < 2; c++) begin
         avail = wp[c] < wn[c];
         // Stalls only occur inside a job, so a channel with work always requests when idle.
         stall = avail && pj[c] > 0 && ($urandom_range(3) == 0);
         if (c == 0) begin
            s0_empty = !avail || stall;
            s0_fi    = avail ? wd[0][wp[0]] : 64'd0;
            s0_last  = avail ? wl[0][wp[0]] : 1'b0;
         end else begin
            s1_empty = !avail || stall;
            s1_fi    = avail ? wd[1][wp[1]] : 64'd0;
            s1_last  = avail ? wl[1][wp[1]] : 1'b0;
         end
      end
   endtask

   task automatic drive_encoder();
      int cur;
      exp_t e;
      enc_m_src_getn = 1'b1;
      enc_m_dst_putn = 1'b1;
      enc_m_endn     = 1'b1;
      e_pulled       = 1'b0;
      if (jidx < NJ) begin
         cur = ex_ch[jidx];
         if (e_phase == 0) begin
            if (!enc_src_empty && wp[cur] < wn[cur] && $urandom_range(3) != 0) begin
               check("enc_fi", enc_fi, wd[cur][wp[cur]]);
               check("enc_m_last", enc_m_last, wl[cur][wp[cur]]);
               enc_m_src_getn = 1'b0;
               e_pulled       = 1'b1;
               e_started      = 1;
               if (wl[cur][wp[cur]]) begin
                  e_phase = 1;
                  e_dcnt  = 0;
               end
            end
            if (e_started != 0) begin
               if ($urandom_range(2) == 0) begin
                  enc_m_dst_putn = 1'b0;
                  e_dst++;
               end
               if ($urandom_range(7) == 0) enc_m_endn = 1'b0;
            end
         end else begin
            e_dcnt++;
            check("drain_src_empty", enc_src_empty, 1);
            check("drain_m_last", enc_m_last, 0);
            if ($urandom_range(2) == 0) enc_m_src_getn = 1'b0;
            if ($urandom_range(2) == 0) begin
               enc_m_dst_putn = 1'b0;
               e_dst++;
            end
            if ((ex_to[jidx] == 0 && e_dcnt == ex_dly[jidx] + 1) || (ex_to[jidx] != 0 && e_dcnt == WDOG)) begin
               if (ex_to[jidx] == 0) enc_m_endn = 1'b0;
               e = '{cur, ex_len[jidx], e_dst, ex_to[jidx], tick + 1};
               sb.push_back(e);
               jidx++;
               e_phase   = 0;
               e_started = 0;
               e_dst     = 0;
            end
         end
      end
   endtask

   task automatic sample_getn();
      int cur;
      cur = (jidx < NJ) ? ex_ch[jidx] : -1;
      pop[0] = !s0_getn;
      pop[1] = !s1_getn;
      if (cur == 0) check("s0_getn_fwd", s0_getn, !e_pulled);
      else          check("s0_getn_hold", s0_getn, 1);
      if (cur == 1) check("s1_getn_fwd", s1_getn, !e_pulled);
      else          check("s1_getn_hold", s1_getn, 1);
   endtask

   initial begin
      rst = 1'b1;
      s0_fi = '0; s0_empty = 1'b1; s0_last = 1'b0;
      s1_fi = '0; s1_empty = 1'b1; s1_last = 1'b0;
      enc_m_src_getn = 1'b1; enc_m_dst_putn = 1'b1; enc_m_endn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_job_src", job_src_words, 0);
      check("rst_job_dst", job_dst_words, 0);
      check("rst_s0_getn", s0_getn, 1);
      check("rst_s1_getn", s1_getn, 1);
      check("rst_enc_src_empty", enc_src_empty, 1);
      check("rst_enc_m_last", enc_m_last, 0);
      check("rst_enc_fi", enc_fi, 0);

      // Abandon a job with reset after two words, then start a clean job on channel 1.
      @(posedge clk); #1;
      rst = 1'b0; s0_empty = 1'b0; s0_fi = 64'h1111_2222_3333_4444; s0_last = 1'b0;
      for (int i = 0; i < 5 && gnt != 2'b01; i++) @(negedge clk);
      check("mid_rst_gnt_ch0", gnt, 2'b01);
      @(posedge clk); #1; enc_m_src_getn = 1'b0;
      @(negedge clk);
      check("mid_rst_s0_getn", s0_getn, 0);
      check("mid_rst_s1_getn", s1_getn, 1);
      check("mid_rst_busy", busy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1; enc_m_src_getn = 1'b1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; s0_empty = 1'b1;
      s1_empty = 1'b0; s1_fi = 64'hAAAA_5555_0F0F_F0F0; s1_last = 1'b1;
      @(negedge clk);
      check("after_rst_gnt", gnt, 0);
      check("after_rst_busy", busy, 0);
      check("after_rst_done", done, 0);
      for (int i = 0; i < 5 && gnt != 2'b10; i++) @(negedge clk);
      check("after_rst_gnt_ch1", gnt, 2'b10);
      check("after_rst_enc_fi", enc_fi, 64'hAAAA_5555_0F0F_F0F0);
      check("after_rst_enc_last", enc_m_last, 1);
      check("after_rst_enc_empty", enc_src_empty, 0);
      @(posedge clk); #1; rst = 1'b1; s1_empty = 1'b1; s1_last = 1'b0;

      // Randomized jobs; grant order comes from a plain round-robin rule over pending jobs.
      njc[0] = $urandom_range(6, 4);
      njc[1] = $urandom_range(6, 3);
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < njc[c]; k++) begin
            lens[c][k] = $urandom_range(6, 1);
            tos[c][k]  = ($urandom_range(3) == 0) ? 1 : 0;
            dlys[c][k] = $urandom_range(4, 0);
         end
      end
      lens[0][0] = 4; tos[0][0] = 0; dlys[0][0] = 0; tos[0][1] = 1;
      for (int c = 0; c < 2; c++) begin
         wn[c] = 0; wp[c] = 0; pj[c] = 0; kk[c] = 0; rem[c] = njc[c];
         for (int k = 0; k < njc[c]; k++) begin
            for (int w = 0; w < lens[c][k]; w++) begin
               wd[c][wn[c]] = {$urandom, $urandom};
               wl[c][wn[c]] = (w == lens[c][k] - 1);
               wn[c]++;
            end
         end
      end
      ptr = 0;
      NJ  = 0;
      while (rem[0] + rem[1] > 0) begin
         if (rem[0] > 0 && rem[1] > 0) pick = ptr;
         else pick = (rem[0] > 0) ? 0 : 1;
         ex_ch[NJ]  = pick;
         ex_len[NJ] = lens[pick][kk[pick]];
         ex_to[NJ]  = tos[pick][kk[pick]];
         ex_dly[NJ] = dlys[pick][kk[pick]];
         kk[pick]++;
         rem[pick]--;
         ptr = 1 - pick;
         NJ++;
      end
      e_phase = 0; e_started = 0; e_dcnt = 0; e_dst = 0; jidx = 0;
      pop[0] = 1'b0; pop[1] = 1'b0;

      @(posedge clk); #1;
      rst    = 1'b0;
      mon_on = 1'b1;
      cyc    = 0;
      while (mon_j < NJ && cyc < 5000) begin
         apply_pops();
         drive_sources();
         #1;
         drive_encoder();
         @(negedge clk);
         sample_getn();
         @(posedge clk); #1;
         cyc++;
      end
      enc_m_src_getn = 1'b1; enc_m_dst_putn = 1'b1; enc_m_endn = 1'b1;
      check("all_jobs_done", mon_j, NJ);
      check("sb_drained", sb.size(), 0);
      repeat (2) @(negedge clk);
      check("final_busy", busy, 0);
      check("final_gnt", gnt, 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
